hamming_link: RTL and testbench
===============================

// Module: hamming_link
// PURPOSE
//   Parameterised single-error-correcting Hamming link: encodes a K-bit data word into an
//   N-bit codeword, injects a caller-supplied error pattern (channel model), then decodes
//   and corrects the received word.
//   Top-level demo/board block; all message outputs are active-low (drive LEDs directly).
//   Outputs are registered; one clock, synchronous active-low reset.
// PARAMETERS
//   P   3   parity-bit count; N = 2**P-1 codeword bits, K = 2**P-P-1 data bits; legal P >= 2
// PORTS
//   clk            in   1  rising-edge clock
//   rst_n          in   1  synchronous reset, active-low
//   data           in   K  data word to transmit (active-high)
//   error_vector   in   N  channel error mask, ACTIVE-LOW: bit=0 flips that codeword bit
//   tx_msg_bar     out  N  ~encoded codeword
//   rx_msg_bar     out  N  ~(codeword XOR error mask) = ~received word
//   ec_data_bar    out  K  ~corrected decoded data
// BEHAVIOUR
//   Interface:
//   - One clock, clk; reset rst_n is synchronous and active-low.
//   Codeword layout:
//   - Position i = 1..N maps to tx_msg bit [i-1].
//   - Parity p_k sits at position 2**k (k = 0..P-1).
//   - Data bits fill the non-power-of-two positions in ascending order;
//     data[0] is at position 3, data[K-1] at position N.
//   Encode:
//   - p_k = XOR of data bits at every position whose index has bit k set.
//   - Even parity over each group.
//   Channel:
//   - rx = tx ^ ~error_vector.
//   Decode:
//   - Syndrome s (P bits) = XOR of indices i over all positions where rx[i-1] = 1.
//   - s = 0: no correction.
//   - s != 0: invert rx bit [s-1].
//   - ec_data is extracted from the corrected word using the same layout.
//   Multiple-bit errors:
//   - Not detected. The syndrome-indicated bit is still flipped (possibly wrong data).
//   - No error flag is provided.
//   Timing:
//   - All logic from the inputs is combinational.
//   - All three outputs register on the same rising edge, giving 1-cycle latency.
//   - Inputs sampled at edge t appear on the outputs after edge t.
//   - No handshake; a new word is accepted every cycle. Outputs of consecutive cycles are independent.
//   Reset:
//   - While rst_n = 0 at a rising edge, all outputs load all-ones (= encoded/decoded zero word, error-free).
//   - Reset asserted mid-stream overrides the input sample of that edge.
//   - The first post-reset edge loads normal results.
//   Outputs are never X after the first clock edge with rst_n = 0.
// TESTING (P=3, K=4, N=7; values are active-high, i.e. outputs inverted and error_vector = ~mask)
//   1. Reset: hold rst_n=0 for 2 clocks -> tx/rx/ec_data_bar all ones.
//      Release reset -> next edge shows new results.
//   2. data=0000, mask=0000000 -> tx=0000000, rx=0000000, ec=0000.
//   3. data=1111, mask=0000001 -> tx=1111111, rx=1111110, ec=1111 (parity p0 error).
//   4. data=0011, mask=0000010 -> tx=0011110, rx=0011100, ec=0011.
//      data=1010, mask=0000100 -> tx=1010010, rx=1010110, ec=1010 (data bit error).
//   5. Sweep all 16 data words x all 8 masks (zero + each single bit) -> ec==data every case.
//      Check the 1-cycle latency against a scoreboard delayed one clock.
//   6. Double error: data=0000, mask=0000011 -> syndrome 3, ec=0001
//      (documented miscorrection, no flag).

Source files
------------

// File: rtl/hamming_link.sv
// Single-error-correcting Hamming link: encode, apply an active-low channel error
// mask, syndrome-decode and correct. All three outputs are registered and active-low.
module hamming_link #(
  parameter  int P = 3,
  localparam int N = (32'sd2 ** P) - 32'sd1,
  localparam int K = (32'sd2 ** P) - P - 32'sd1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] data,
  input  logic [N-1:0] error_vector,
  output logic [N-1:0] tx_msg_bar,
  output logic [N-1:0] rx_msg_bar,
  output logic [K-1:0] ec_data_bar
);

  // Position i (1-based) lives in bit [i-1]; parity bits sit at the power-of-two positions.
  function automatic logic [N-1:0] encode(input logic [K-1:0] d);
    logic [N-1:0] cw;
    logic         p;
    int           j;
    cw = '0;
    j  = 32'sd0;
    for (int i = 32'sd1; i <= N; i++) begin
      if ((i & (i - 32'sd1)) != 32'sd0) begin
        cw[i-1] = d[j];
        j       = j + 32'sd1;
      end else begin
        cw[i-1] = 1'b0;
      end
    end
    // Parity slots are still zero while their own group is summed, so no exclusion is needed.
    for (int k = 32'sd0; k < P; k++) begin
      p = 1'b0;
      for (int i = 32'sd1; i <= N; i++) begin
        if (i[k]) begin
          p = p ^ cw[i-1];
        end else begin
          p = p;
        end
      end
      cw[(32'sd1 << k) - 32'sd1] = p;
    end
    return cw;
  endfunction

  function automatic logic [P-1:0] syndrome(input logic [N-1:0] rx);
    logic [P-1:0] s;
    s = '0;
    for (int i = 32'sd1; i <= N; i++) begin
      if (rx[i-1]) begin
        s = s ^ i[P-1:0];
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  function automatic logic [N-1:0] correct(input logic [N-1:0] rx, input logic [P-1:0] s);
    logic [N-1:0] c;
    c = rx;
    if (s != '0) begin
      c[s - 1'b1] = ~c[s - 1'b1];
    end else begin
      c = rx;
    end
    return c;
  endfunction

  function automatic logic [K-1:0] extract(input logic [N-1:0] cw);
    logic [K-1:0] d;
    int           j;
    d = '0;
    j = 32'sd0;
    for (int i = 32'sd1; i <= N; i++) begin
      if ((i & (i - 32'sd1)) != 32'sd0) begin
        d[j] = cw[i-1];
        j    = j + 32'sd1;
      end else begin
        j    = j;
      end
    end
    return d;
  endfunction

  logic [N-1:0] tx_s;
  logic [N-1:0] rx_s;
  logic [P-1:0] syn_s;
  logic [N-1:0] fix_s;
  logic [K-1:0] ec_s;

  logic [N-1:0] tx_r;
  logic [N-1:0] rx_r;
  logic [K-1:0] ec_r;

  // Encode, channel and decode path, purely combinational from the inputs.
  always_comb begin
    tx_s  = encode(data);
    rx_s  = tx_s ^ ~error_vector;
    syn_s = syndrome(rx_s);
    fix_s = correct(rx_s, syn_s);
    ec_s  = extract(fix_s);
  end

  // Output registers; reset loads the inverted all-zero error-free word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_r <= '1;
      rx_r <= '1;
      ec_r <= '1;
    end else begin
      tx_r <= ~tx_s;
      rx_r <= ~rx_s;
      ec_r <= ~ec_s;
    end
  end

  assign tx_msg_bar  = tx_r;
  assign rx_msg_bar  = rx_r;
  assign ec_data_bar = ec_r;

endmodule

// File: tb/tb_hamming_link.sv
// Self-checking bench for hamming_link: nearest-codeword reference model,
// one-cycle-delayed scoreboard, directed literal vectors and a random stream.
module tb_hamming_link;
  localparam int P = 3;
  localparam int N = 7;
  localparam int K = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [K-1:0] data;
  logic [N-1:0] error_vector;
  logic [N-1:0] tx_msg_bar;
  logic [N-1:0] rx_msg_bar;
  logic [K-1:0] ec_data_bar;

  int tests = 0;
  int fails = 0;

  hamming_link #(.P(P)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .error_vector(error_vector),
    .tx_msg_bar(tx_msg_bar), .rx_msg_bar(rx_msg_bar), .ec_data_bar(ec_data_bar)
  );

  always #5 clk = ~clk;

  // Reference encoder: scatter data into non-power-of-two slots, then even parity per group.
  function automatic logic [N-1:0] m_encode(input logic [K-1:0] d);
    logic [N-1:0] cw;
    logic [N-1:0] grp;
    int j;
    cw = '0;
    j  = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ($countones(pos) != 1) begin
        cw[pos-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < P; k++) begin
      grp = '0;
      for (int pos = 1; pos <= N; pos++)
        if ((pos & (1 << k)) != 0) grp[pos-1] = cw[pos-1];
      cw[(1 << k) - 1] = (($countones(grp) % 2) == 1);
    end
    return cw;
  endfunction

  // Reference decoder: the code is perfect, so exactly one codeword lies within distance 1.
  function automatic logic [K-1:0] m_decode(input logic [N-1:0] rx);
    for (int c = 0; c < (1 << K); c++)
      if ($countones(m_encode(c[K-1:0]) ^ rx) <= 1) return c[K-1:0];
    return '0;
  endfunction

  logic [N-1:0] exp_tx;
  logic [N-1:0] exp_rx;
  logic [K-1:0] exp_ec;
  logic         exp_valid = 1'b0;

  // Scoreboard: what the outputs must show after this edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_tx <= '1;
      exp_rx <= '1;
      exp_ec <= '1;
    end else begin
      exp_tx <= ~m_encode(data);
      exp_rx <= ~(m_encode(data) ^ ~error_vector);
      exp_ec <= ~m_decode(m_encode(data) ^ ~error_vector);
    end
    exp_valid <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_lit(input logic [K-1:0] d, input logic [N-1:0] mask,
                           input logic [N-1:0] etx, input logic [N-1:0] erx,
                           input logic [K-1:0] eec);
    logic [N-1:0] t;
    logic [N-1:0] r;
    logic [K-1:0] e;
    data = d;
    error_vector = ~mask;
    @(posedge clk);
    @(negedge clk);
    t = ~tx_msg_bar;
    r = ~rx_msg_bar;
    e = ~ec_data_bar;
    check("lit_tx", t, etx);
    check("lit_rx", r, erx);
    check("lit_ec", e, eec);
  endtask

  initial begin
    logic [31:0]  rnd;
    logic [N-1:0] mask;
    logic [K-1:0] e;

    rst_n = 1'b0;
    rnd = $urandom;
    data = rnd[K-1:0];
    error_vector = rnd[N+K-1:K];

    fork
      forever begin
        @(negedge clk);
        if (exp_valid) begin
          check("tx_msg_bar", tx_msg_bar, exp_tx);
          check("rx_msg_bar", rx_msg_bar, exp_rx);
          check("ec_data_bar", ec_data_bar, exp_ec);
        end
      end
    join_none

    // Pin the model against hand-computed codewords.
    check("model_enc_1111", m_encode(4'b1111), 7'b1111111);
    check("model_enc_0011", m_encode(4'b0011), 7'b0011110);
    check("model_enc_1010", m_encode(4'b1010), 7'b1010010);
    check("model_dec_dbl", m_decode(7'b0000011), 4'b0001);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx_msg_bar, 7'h7f);
    check("rst_rx", rx_msg_bar, 7'h7f);
    check("rst_ec", ec_data_bar, 4'hf);
    rst_n = 1'b1;

    apply_lit(4'b0000, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0000);
    apply_lit(4'b1111, 7'b0000001, 7'b1111111, 7'b1111110, 4'b1111);
    apply_lit(4'b0011, 7'b0000010, 7'b0011110, 7'b0011100, 4'b0011);
    apply_lit(4'b1010, 7'b0000100, 7'b1010010, 7'b1010110, 4'b1010);
    apply_lit(4'b0000, 7'b0000011, 7'b0000000, 7'b0000011, 4'b0001);

    // Every data word against the clean channel and every single-bit error.
    for (int d = 0; d < (1 << K); d++) begin
      for (int m = 0; m <= N; m++) begin
        mask = (m == 0) ? '0 : 7'(1 << (m - 1));
        data = d[K-1:0];
        error_vector = ~mask;
        @(posedge clk);
        @(negedge clk);
        e = ~ec_data_bar;
        check("sweep_ec", e, d[K-1:0]);
      end
    end

    // Random stream with arbitrary masks and one mid-stream reset pulse.
    for (int i = 0; i < 300; i++) begin
      rnd = $urandom;
      data = rnd[K-1:0];
      error_vector = rnd[N+K-1:K];
      rst_n = (i != 150) && (i != 151);
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
